// File: rtl/kisc_alu_if.sv
// Operand/result bundle between the KISC-V microcode sequencer and its ALU.
// There is no handshake: the operands are sampled and the results are valid
// combinationally in every cycle; alu_q/cmp_q are the same results one clock later.
interface kisc_alu_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_out;
    logic             cmp_flag;
    logic [WIDTH-1:0] alu_q;
    logic             cmp_q;

    // Sequencer side: drives the op and operands, consumes the results
    modport master (
        output alu_op, a, b,
        input  alu_out, cmp_flag, alu_q, cmp_q
    );

    // ALU side
    modport slave (
        input  alu_op, a, b,
        output alu_out, cmp_flag, alu_q, cmp_q
    );
endinterface

// File: rtl/kisc_alu.sv
// RV32I integer ALU: combinational result and branch-compare flag,
// plus registered copies of both results for debug and pipelined use.
module kisc_alu #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rts_n,
    kisc_alu_if.slave   bus
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       shamt;
    logic             lt_signed;
    logic             lt_unsigned;
    logic             equal;
    logic [WIDTH-1:0] result;
    logic             flag;

    assign op_a        = bus.a;
    assign op_b        = bus.b;
    // Only the low five bits of b select the shift distance
    assign shamt       = op_b[4:0];
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;
    assign equal       = op_a == op_b;

    // Result decode; bit 3 only matters for ADD/SUB and SRL/SRA because
    // I-type immediates put arbitrary data in that position for other ops
    always_comb begin
        result = '0;
        case (bus.alu_op[2:0])
            3'b000: result = bus.alu_op[3] ? (op_a - op_b) : (op_a + op_b);
            3'b001: result = op_a << shamt;
            3'b010: result = {{(WIDTH-1){1'b0}}, lt_signed};
            3'b011: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            3'b100: result = op_a ^ op_b;
            3'b101: result = bus.alu_op[3] ? WIDTH'($signed(op_a) >>> shamt)
                                           : (op_a >> shamt);
            3'b110: result = op_a | op_b;
            3'b111: result = op_a & op_b;
            default: result = '0;
        endcase
    end

    // Branch condition from the branch funct3; 010/011 alias the signed/unsigned less-than
    always_comb begin
        flag = 1'b0;
        case (bus.alu_op[2:0])
            3'b000: flag = equal;
            3'b001: flag = ~equal;
            3'b010: flag = lt_signed;
            3'b011: flag = lt_unsigned;
            3'b100: flag = lt_signed;
            3'b101: flag = ~lt_signed;
            3'b110: flag = lt_unsigned;
            3'b111: flag = ~lt_unsigned;
            default: flag = 1'b0;
        endcase
    end

    assign bus.alu_out  = result;
    assign bus.cmp_flag = flag;

    // Registered copies: cleared immediately by reset, then capture every rising edge
    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            bus.alu_q <= '0;
            bus.cmp_q <= 1'b0;
        end else begin
            bus.alu_q <= result;
            bus.cmp_q <= flag;
        end
    end
endmodule

// File: tb/tb_kisc_alu.sv
// Bench for kisc_alu: directed corner cases plus random ops, checked by a
// scoreboard against a behavioural model of the RV32I ALU rules.
module tb_kisc_alu;
    localparam int W = 32;

    logic clk;
    logic rts_n;

    kisc_alu_if #(.WIDTH(W)) bus ();

    kisc_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rts_n (rts_n),
        .bus   (bus)
    );

    // Entry layout: {check_registered, cmp, result}
    logic [W+1:0] exp_q[$];
    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic is_less_signed(logic [W-1:0] x, logic [W-1:0] y);
        if (x[W-1] != y[W-1]) return x[W-1];   // negative one is smaller
        return x < y;
    endfunction

    function automatic logic [W-1:0] model_res(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y);
        int unsigned sh;
        logic [W-1:0] fill;
        sh = int'(y % 32);
        case (op[2:0])
            3'd0: return op[3] ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return is_less_signed(x, y) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: begin
                fill = (op[3] && x[W-1]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (x >> sh) | fill;
            end
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic model_cmp(logic [2:0] f3, logic [W-1:0] x, logic [W-1:0] y);
        case (f3)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2, 3'd4: return is_less_signed(x, y);
            3'd5: return !is_less_signed(x, y);
            3'd3, 3'd6: return x < y;
            default: return !(x < y);
        endcase
    endfunction

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit chk_reg);
        @(negedge clk);
        bus.alu_op = op;
        bus.a      = x;
        bus.b      = y;
        exp_q.push_back({chk_reg, model_cmp(op[2:0], x, y), model_res(op, x, y)});
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    // Inputs change on the falling edge, so just after the rising edge both the
    // combinational outputs and the freshly captured registers reflect one entry.
    always @(posedge clk) begin
        logic [W+1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("alu_out op=%h", bus.alu_op), bus.alu_out, e[W-1:0]);
            check($sformatf("cmp_flag op=%h", bus.alu_op), {31'b0, bus.cmp_flag}, {31'b0, e[W]});
            if (e[W+1]) begin
                check($sformatf("alu_q op=%h", bus.alu_op), bus.alu_q, e[W-1:0]);
                check($sformatf("cmp_q op=%h", bus.alu_op), {31'b0, bus.cmp_q}, {31'b0, e[W]});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] op;
        logic [W-1:0] x;
        int wait_cycles;
        checks = 0;
        errors = 0;
        rts_n      = 1'b0;
        bus.alu_op = 4'd0;
        bus.a      = '0;
        bus.b      = '0;

        // Reset state before any clock edge
        #2;
        check("rst_init_alu_q", bus.alu_q, 32'd0);
        check("rst_init_cmp_q", {31'b0, bus.cmp_q}, 32'd0);
        @(posedge clk);
        #3 rts_n = 1'b1;

        // Directed corner cases
        apply(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b1);          // ADD wrap -> 0
        apply(4'b1000, 32'h0, 32'h1, 1'b1);                  // SUB wrap -> FFFFFFFF
        apply(4'b0101, 32'h8000_0000, 32'h24, 1'b1);         // SRL by 4
        apply(4'b1101, 32'h8000_0000, 32'h24, 1'b1);         // SRA by 4
        apply(4'b0001, 32'h8000_0000, 32'h24, 1'b1);         // SLL out the top
        apply(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1);          // SLT -1 < 1
        apply(4'b0011, 32'hFFFF_FFFF, 32'h1, 1'b1);          // SLTU
        apply(4'b0100, 32'hFFFF_FFFF, 32'h1, 1'b1);          // BLT flag
        apply(4'b0110, 32'hFFFF_FFFF, 32'h1, 1'b1);          // BLTU flag
        apply(4'b0000, 32'h5, 32'h5, 1'b1);                  // BEQ
        apply(4'b0001, 32'h5, 32'h5, 1'b1);                  // BNE
        apply(4'b0101, 32'h5, 32'h5, 1'b1);                  // BGE
        apply(4'b0111, 32'h5, 32'h5, 1'b1);                  // BGEU
        apply(4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);  // AND, bit 3 ignored
        apply(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);  // XOR, bit 3 ignored
        apply(4'b1101, 32'h8000_0000, 32'h1F, 1'b1);         // SRA by 31
        apply(4'b1101, 32'h9234_5678, 32'hFFFF_FFE0, 1'b1);  // shift amount 0, upper b ignored
        apply(4'b0101, 32'h9234_5678, 32'h20, 1'b1);         // SRL amount 0
        apply(4'b1001, 32'h0000_0001, 32'h3F, 1'b1);         // SLL by 31, bit 3 ignored

        // Random ops
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = rand_operand();
            apply(op, x, ($urandom_range(0, 3) == 0) ? x : rand_operand(), 1'b1);
        end

        // Reset asserted between edges mid-operation
        apply(4'b0110, 32'h1234_0000, 32'h0000_5678, 1'b1);
        @(posedge clk);
        #3 rts_n = 1'b0;
        #1;
        check("rst_async_alu_q", bus.alu_q, 32'd0);
        check("rst_async_cmp_q", {31'b0, bus.cmp_q}, 32'd0);
        apply(4'b0000, 32'h1, 32'h2, 1'b0);                  // combinational path unaffected
        @(posedge clk);
        #2;
        check("rst_hold_alu_q", bus.alu_q, 32'd0);
        check("rst_hold_cmp_q", {31'b0, bus.cmp_q}, 32'd0);
        #1 rts_n = 1'b1;
        apply(4'b1101, 32'hC000_0000, 32'h1, 1'b1);          // next edge captures prior alu_out
        apply(4'b0111, 32'h3, 32'h3, 1'b1);

        // Drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
